// File: rtl/gpio_pkg.sv
// Shared defaults for the GPIO input controller.
package gpio_pkg;
  localparam int GPIO_WIDTH       = 32;
  localparam int GPIO_SYNC_STAGES = 2;
  localparam int GPIO_DEB_CYCLES  = 4;
endpackage

// File: rtl/gpio_in_bit.sv
// One pin: synchroniser chain, debounce counter and debounced level flop.
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DEB_CYCLES  = GPIO_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic deb,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   deb_q, deb_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  // The counter tracks how many consecutive synchronised samples disagree with
  // the accepted level; the pulses fire on the edge the level is accepted.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pin};
    deb_d      = deb_q;
    cnt_d      = '0;
    rise_pulse = 1'b0;
    fall_pulse = 1'b0;
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d      = ~deb_q;
        rise_pulse = ~deb_q;
        fall_pulse = deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb = deb_q;
endmodule

// File: rtl/gpio_in_ctrl.sv
// GPIO input block: per-pin debounce, optionally byte-swapped capture register
// and sticky edge-interrupt flags.
module gpio_in_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int DEB_CYCLES  = GPIO_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             en,
  input  logic             swap_en,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);
  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] deb, rise, fall, deb_swapped;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .pin       (pins_in[i]),
      .deb       (deb[i]),
      .rise_pulse(rise[i]),
      .fall_pulse(fall[i])
    );
  end

  for (genvar k = 0; k < NB; k++) begin : g_swap
    assign deb_swapped[8*k +: 8] = deb[8*(NB-1-k) +: 8];
  end

  // A set on the same edge as a clear wins, so no edge is ever lost.
  always_comb begin
    din_d     = din_q;
    pending_d = (pending_q & ~irq_clear) | (rise & rise_en) | (fall & fall_en);
    if (en) begin
      din_d = swap_en ? deb_swapped : deb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      din_q     <= '0;
      pending_q <= '0;
    end else begin
      din_q     <= din_d;
      pending_q <= pending_d;
    end
  end

  assign din     = din_q;
  assign pending = pending_q;
  assign irq     = |pending_q;
endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Bench for gpio_in_ctrl: window-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gpio_in_ctrl;
  localparam int W  = 32;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int HL = SS + DC - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pins_in = '0;
  logic         en = 1'b0;
  logic         swap_en = 1'b0;
  logic [W-1:0] rise_en = '0;
  logic [W-1:0] fall_en = '0;
  logic [W-1:0] irq_clear = '0;
  logic [W-1:0] din, pending;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_in_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .DEB_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .pins_in  (pins_in),
    .en       (en),
    .swap_en  (swap_en),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .irq_clear(irq_clear),
    .din      (din),
    .pending  (pending),
    .irq      (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] byteswap(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < W/8; k++) r[8*k +: 8] = v[8*(W/8-1-k) +: 8];
    return r;
  endfunction

  // Reference model: a bit accepts a new level once the last DC samples seen
  // by the debouncer (pins delayed by SS edges) all disagree with it.
  logic [W-1:0] m_deb, m_din, m_pend;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    logic [W-1:0] flip, old;
    if (reset) begin
      exp_q = {};
      for (int i = 0; i < HL; i++) exp_q.push_front('0);
      m_deb  = '0;
      m_din  = '0;
      m_pend = '0;
    end else begin
      old  = m_deb;
      flip = '1;
      for (int j = SS - 1; j < SS - 1 + DC; j++) flip &= exp_q[j] ^ old;
      if (en) m_din = swap_en ? byteswap(old) : old;
      m_pend = (m_pend & ~irq_clear) | (flip & ~old & rise_en) | (flip & old & fall_en);
      m_deb  = old ^ flip;
      exp_q.push_front(pins_in);
      void'(exp_q.pop_back());
    end
    #1;
    check("model_din", din, m_din);
    check("model_pending", pending, m_pend);
    check("model_irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, |m_pend});
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_pin0(input int n);
    @(negedge clk);
    pins_in = 32'h1;
    repeat (n) @(negedge clk);
    pins_in = '0;
  endtask

  initial begin
    step(3);
    check("reset_din", din, '0);
    check("reset_pending", pending, '0);
    check("reset_irq", {31'b0, irq}, '0);

    // capture, swapped then straight
    @(negedge clk);
    reset = 1'b0; pins_in = 32'h11223344; en = 1'b1; swap_en = 1'b1;
    step(7);
    check("din_swapped", din, 32'h44332211);
    @(negedge clk); swap_en = 1'b0;
    step(1);
    check("din_straight", din, 32'h11223344);

    // glitch rejection then accepted pulse
    @(negedge clk); reset = 1'b1;
    step(2);
    @(negedge clk); reset = 1'b0; pins_in = '0; rise_en = 32'h1;
    pulse_pin0(3);
    step(10);
    check("glitch_pending", pending, '0);
    check("glitch_din", din, '0);
    pulse_pin0(4);
    step(10);
    check("pulse_pending", pending, 32'h1);
    check("pulse_irq", {31'b0, irq}, 32'h1);

    // falling-edge flag and write-1-to-clear
    @(negedge clk); irq_clear = '1;
    @(negedge clk); irq_clear = '0; rise_en = '0; fall_en = 32'h20; pins_in = 32'h20;
    step(10);
    check("fall_before", pending, '0);
    @(negedge clk); pins_in = '0;
    step(10);
    check("fall_pending", pending, 32'h20);
    check("fall_irq", {31'b0, irq}, 32'h1);
    @(negedge clk); irq_clear = 32'h20;
    step(1);
    check("clear_pending", pending, '0);
    check("clear_irq", {31'b0, irq}, '0);

    // set beats a coincident clear
    @(negedge clk); irq_clear = '0; rise_en = 32'h8; pins_in = 32'h8;
    step(5);
    check("coinc_before", pending, '0);
    @(negedge clk); irq_clear = 32'h8;
    step(1);
    check("coinc_set_wins", pending, 32'h8);
    check("coinc_irq", {31'b0, irq}, 32'h1);
    @(negedge clk); irq_clear = '0;
    step(1);
    check("coinc_hold", pending, 32'h8);

    // capture disabled holds din
    @(negedge clk); en = 1'b0; pins_in = '1;
    step(12);
    check("hold_din", din, 32'h8);
    check("hold_pending", pending, 32'h8);

    // reset in the middle of a debounce restarts the full latency
    @(negedge clk); reset = 1'b1;
    step(2);
    check("rst_din", din, '0);
    check("rst_pending", pending, '0);
    @(negedge clk); reset = 1'b0; pins_in = '0; en = 1'b1; rise_en = 32'h1; fall_en = '0;
    step(8);
    @(negedge clk); pins_in = 32'h1;
    step(4);
    @(negedge clk); reset = 1'b1;
    step(2);
    check("mid_rst_din", din, '0);
    check("mid_rst_pending", pending, '0);
    check("mid_rst_irq", {31'b0, irq}, '0);
    @(negedge clk); reset = 1'b0;
    step(5);
    check("relaunch_e5_pending", pending, '0);
    check("relaunch_e5_din", din, '0);
    step(1);
    check("relaunch_e6_pending", pending, 32'h1);
    check("relaunch_e6_irq", {31'b0, irq}, 32'h1);
    step(1);
    check("relaunch_e7_din", din, 32'h1);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
